hpdcache_arb_mux_buf: RTL and testbench
=======================================

Name: hpdcache_arb_mux_buf

Overview:
- Consumer stage directly downstream of the fixed-priority arbiter (hpdcache_fxarb).
- Takes the arbiter's one-hot grant, muxes the granted requester's payload and index, and stores them in a 2-entry registered buffer.
- Drives the arbiter's ready_i from buffer space, so a grant is held until the buffer can accept it.
- Gives the downstream consumer a registered valid/ready interface with no combinational path from out_ready_i back to the requesters.

Parameters:
- N, 4: number of requesters; N >= 2.
- W, 32: payload width per requester in bits.
- IDW, $clog2(N): width of the source-index output; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  N  per-requester valid; bit i is also the request bit driven to the arbiter's req_i[i].
- req_data_i  in  N*W  packed payloads; requester i occupies bits [i*W +: W].
- gnt_i  in  N  one-hot (or zero) grant from the arbiter's gnt_o.
- arb_ready_o  out  1  drives the arbiter's ready_i.
- req_ready_o  out  N  per-requester accept strobe.
- out_valid_o  out  1  buffer head is valid.
- out_ready_i  in  1  downstream accepts the head.
- out_data_o  out  W  head payload.
- out_id_o  out  IDW  head source index.
- err_o  out  1  sticky protocol-error flag; see Optional Feature.

Behaviour:
- Storage: 2 entries of {W data, IDW id}; read pointer rd_q and write pointer wr_q are 1 bit each; cnt_q is 2 bits, range 0..2.
- Reset (async, rst_i=1): cnt_q=0, rd_q=0, wr_q=0, err_q=0.
  - Outputs during and after reset: out_valid_o=0, arb_ready_o=1, req_ready_o=0 unless a grant is present, err_o=0.
  - Entry contents are not reset; out_data_o and out_id_o are don't-care while out_valid_o=0.
- arb_ready_o = (cnt_q != 2). This is registered-state only, with no path from out_ready_i.
- req_ready_o[i] = gnt_i[i] & arb_ready_o.
- push = |(gnt_i & req_valid_i) & arb_ready_o.
  - A grant to a non-requesting requester does not push.
- pop = out_valid_o & out_ready_i, where out_valid_o = (cnt_q != 0).
- Mux: one-hot AND-OR of req_data_i by gnt_i; id = index of the set gnt_i bit, 0 when gnt_i is zero. No priority encoding is done here.
- On push: write entry[wr_q], then wr_q toggles.
- On pop: rd_q toggles.
- Counter update: cnt_q += push - pop.
  - Simultaneous push and pop at cnt_q=1 leaves cnt_q at 1.
  - At cnt_q=2, push is impossible; pop brings it to 1, and arb_ready_o rises the following cycle.
  - At cnt_q=0, pop is impossible.
- out_data_o / out_id_o = entry[rd_q].
- Latency: a granted request accepted in cycle t is visible on the outputs in cycle t+1 (no bypass).
- Throughput: 1 transfer/cycle while downstream drains each cycle.
- Backpressure: while full, arb_ready_o=0. The arbiter then holds its grant (wait state), so the held requester is accepted in the first cycle after space frees.
- Reset mid-operation clears all state immediately; buffered entries are discarded and no partial transfer survives.

Optional Feature:
- Macro: HPDCACHE_ARB_MUX_BUF_CHECK_EN.
- When defined, err_q is set (sticky until reset) in any cycle with:
  - gnt_i not one-hot0, or
  - gnt_i nonzero while (gnt_i & req_valid_i) is zero and arb_ready_o=1.
  - err_o = err_q.
- When undefined: err_o is tied 0 and no check logic is synthesised. Data-path behaviour is identical either way.

Test Plan (N=4, W=8):
- Reset: assert rst_i mid-stream with cnt_q=2 -> same cycle out_valid_o=0, arb_ready_o=1, err_o=0; no stale entry appears after release.
- Single transfer: req_valid_i=4'b0100, gnt_i=4'b0100, data[2]=8'hA5, out_ready_i=1 -> req_ready_o=4'b0100; next cycle out_valid_o=1, out_data_o=8'hA5, out_id_o=2.
- Fill/backpressure: out_ready_i=0; push 8'h11 (id 0) then 8'h22 (id 1) -> arb_ready_o=0 from the cycle after the second push, and a third grant (id 3) stalls. Raise out_ready_i: 8'h11 is popped first, then 8'h22, and id 3 is accepted one cycle after the first pop.
- Streaming: a continuous grant alternating ids 1/2 with out_ready_i=1 -> one output per cycle in order, cnt_q stays 1, no bubbles.
- Simultaneous push and pop at cnt_q=1 -> cnt_q stays 1; pointers wrap 1->0 correctly over 4 transfers.
- Check feature (macro defined): gnt_i=4'b0011 for one cycle -> err_o=1 the next cycle and stays 1 until rst_i. With the macro undefined, the same stimulus leaves err_o=0.

Source files
------------

// File: rtl/hpdcache_arb_mux_buf.sv
// hpdcache_arb_mux_buf: consumer stage behind the fixed-priority arbiter.
// It muxes the one-hot granted payload and index into a 2-entry registered
// buffer. The arbiter ready is derived from buffer occupancy only.
// Optional protocol checker: define HPDCACHE_ARB_MUX_BUF_CHECK_EN.
module hpdcache_arb_mux_buf #(
  parameter  int unsigned N   = 4,
  parameter  int unsigned W   = 32,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N-1:0]         req_valid_i,
  input  logic [N*W-1:0]       req_data_i,
  input  logic [N-1:0]         gnt_i,
  output logic                 arb_ready_o,
  output logic [N-1:0]         req_ready_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [W-1:0]         out_data_o,
  output logic [IDW-1:0]       out_id_o,
  output logic                 err_o
);

  localparam logic [1:0] CNT_FULL = 2'd2;

  logic [1:0]     cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [W-1:0]   data_q [2];
  logic [W-1:0]   data_d [2];
  logic [IDW-1:0] id_q   [2];
  logic [IDW-1:0] id_d   [2];

  logic           arb_ready;
  logic           push;
  logic           pop;
  logic [W-1:0]   mux_data;
  logic [IDW-1:0] mux_id;

  // One-hot AND-OR mux of the granted payload and its index (0 when no grant).
  always_comb begin
    mux_data = '0;
    mux_id   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_i[i]) begin
        mux_data = mux_data | req_data_i[i*W +: W];
        mux_id   = mux_id | IDW'(i);
      end
    end
  end

  // Buffer control: push/pop handshakes, pointer and occupancy next state.
  always_comb begin
    arb_ready = (cnt_q != CNT_FULL);
    push      = (|(gnt_i & req_valid_i)) & arb_ready;
    pop       = (cnt_q != 2'd0) & out_ready_i;

    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    data_d = data_q;
    id_d   = id_q;

    if (push) begin
      data_d[wr_q] = mux_data;
      id_d[wr_q]   = mux_id;
      wr_d         = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with asynchronous reset; buffered entries are discarded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

  // Entry storage is not reset; it is only observed while out_valid_o is high.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
    id_q   <= id_d;
  end

  assign arb_ready_o = arb_ready;
  assign req_ready_o = gnt_i & {N{arb_ready}};
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = data_q[rd_q];
  assign out_id_o    = id_q[rd_q];

`ifdef HPDCACHE_ARB_MUX_BUF_CHECK_EN
  logic err_q, err_d;
  logic gnt_multi;
  logic gnt_orphan;

  // Sticky flag for a multi-hot grant or a grant to an idle requester.
  always_comb begin
    gnt_multi  = ((gnt_i & (gnt_i - N'(1))) != '0);
    gnt_orphan = (gnt_i != '0) & ((gnt_i & req_valid_i) == '0) & arb_ready;
    err_d      = err_q | gnt_multi | gnt_orphan;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpdcache_arb_mux_buf.sv
// Directed testbench for hpdcache_arb_mux_buf (N=4, W=8).
module tb_hpdcache_arb_mux_buf;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned IDW = 2;

`ifdef HPDCACHE_ARB_MUX_BUF_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_valid_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   gnt_i;
  logic           arb_ready_o;
  logic [N-1:0]   req_ready_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [W-1:0]   out_data_o;
  logic [IDW-1:0] out_id_o;
  logic           err_o;

  int n_checks = 0;
  int n_fail   = 0;

  hpdcache_arb_mux_buf #(.N(N), .W(W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .gnt_i       (gnt_i),
    .arb_ready_o (arb_ready_o),
    .req_ready_o (req_ready_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_id_o    (out_id_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] g, input int idx, input logic [W-1:0] d);
    req_valid_i = v;
    gnt_i       = g;
    req_data_i  = '0;
    req_data_i[idx*W +: W] = d;
  endtask

  task automatic idle();
    req_valid_i = '0;
    gnt_i       = '0;
    req_data_i  = '0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    out_ready_i = 1'b0;
    idle();
    #2;
    n_checks++;
    if (out_valid_o !== 1'b0 || arb_ready_o !== 1'b1 || req_ready_o !== 4'b0000 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b arb_ready=%b req_ready=%b err=%b, required 0 1 0000 0",
               out_valid_o, arb_ready_o, req_ready_o, err_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready_i = 1'b1;
    drive(4'b0100, 4'b0100, 2, 8'hA5);
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_req_ready: got %b, required 0100", req_ready_o);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 8'hA5 || out_id_o !== 2'd2) begin
      n_fail++;
      $display("FAIL single_out: valid=%b data=%h id=%0d, required 1 a5 2", out_valid_o, out_data_o, out_id_o);
    end
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: valid=%b, required 0", out_valid_o);
    end
  endtask

  task automatic test_fill_backpressure();
    out_ready_i = 1'b0;
    drive(4'b0001, 4'b0001, 0, 8'h11);
    tick();
    n_checks++;
    if (arb_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_one_ready: arb_ready=%b, required 1", arb_ready_o);
    end
    drive(4'b0010, 4'b0010, 1, 8'h22);
    tick();
    n_checks++;
    if (arb_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full_ready: arb_ready=%b, required 0", arb_ready_o);
    end
    drive(4'b1000, 4'b1000, 3, 8'h33);
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL fill_stall: req_ready=%b, required 0000", req_ready_o);
    end
    tick();
    n_checks++;
    if (arb_ready_o !== 1'b0 || out_data_o !== 8'h11 || out_id_o !== 2'd0) begin
      n_fail++;
      $display("FAIL fill_hold: arb_ready=%b data=%h id=%0d, required 0 11 0", arb_ready_o, out_data_o, out_id_o);
    end
    out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 8'h22 || out_id_o !== 2'd1 ||
        arb_ready_o !== 1'b1 || req_ready_o !== 4'b1000) begin
      n_fail++;
      $display("FAIL fill_first_pop: valid=%b data=%h id=%0d arb_ready=%b req_ready=%b, required 1 22 1 1 1000",
               out_valid_o, out_data_o, out_id_o, arb_ready_o, req_ready_o);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 8'h33 || out_id_o !== 2'd3) begin
      n_fail++;
      $display("FAIL fill_held_accept: valid=%b data=%h id=%0d, required 1 33 3", out_valid_o, out_data_o, out_id_o);
    end
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_drain: valid=%b, required 0", out_valid_o);
    end
  endtask

  task automatic test_streaming();
    logic [N-1:0] g;
    out_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = (k % 2 == 0) ? 4'b0010 : 4'b0100;
      drive(g, g, (k % 2 == 0) ? 1 : 2, 8'(8'h40 + k));
      #1;
      n_checks++;
      if (req_ready_o !== g) begin
        n_fail++;
        $display("FAIL stream_req_ready[%0d]: got %b, required %b", k, req_ready_o, g);
      end
      if (k > 0) begin
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'(8'h40 + k - 1) ||
            out_id_o !== (((k - 1) % 2 == 0) ? 2'd1 : 2'd2)) begin
          n_fail++;
          $display("FAIL stream_out[%0d]: valid=%b data=%h id=%0d, required 1 %h %0d", k, out_valid_o,
                   out_data_o, out_id_o, 8'(8'h40 + k - 1), ((k - 1) % 2 == 0) ? 1 : 2);
        end
      end
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 8'h45 || out_id_o !== 2'd2) begin
      n_fail++;
      $display("FAIL stream_last: valid=%b data=%h id=%0d, required 1 45 2", out_valid_o, out_data_o, out_id_o);
    end
    tick();
  endtask

  task automatic test_push_pop_cnt1();
    logic [W-1:0] exp_d;
    out_ready_i = 1'b0;
    drive(4'b0001, 4'b0001, 0, 8'h80);
    tick();
    out_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(4'b1000, 4'b1000, 3, 8'(8'h80 + k));
      #1;
      exp_d = 8'(8'h80 + k - 1);
      n_checks++;
      if (out_valid_o !== 1'b1 || arb_ready_o !== 1'b1 || out_data_o !== exp_d ||
          out_id_o !== ((k == 1) ? 2'd0 : 2'd3)) begin
        n_fail++;
        $display("FAIL pp_cnt1[%0d]: valid=%b arb_ready=%b data=%h id=%0d, required 1 1 %h %0d", k,
                 out_valid_o, arb_ready_o, out_data_o, out_id_o, exp_d, (k == 1) ? 0 : 3);
      end
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 8'h84 || out_id_o !== 2'd3) begin
      n_fail++;
      $display("FAIL pp_last: valid=%b data=%h id=%0d, required 1 84 3", out_valid_o, out_data_o, out_id_o);
    end
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_drain: valid=%b err=%b, required 0 0", out_valid_o, err_o);
    end
  endtask

  task automatic test_reset_mid();
    out_ready_i = 1'b0;
    drive(4'b0001, 4'b0001, 0, 8'hC1);
    tick();
    drive(4'b0010, 4'b0010, 1, 8'hC2);
    tick();
    idle();
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (out_valid_o !== 1'b0 || arb_ready_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b arb_ready=%b err=%b, required 0 1 0", out_valid_o, arb_ready_o, err_o);
    end
    tick();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (out_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stale: valid=%b, required 0", out_valid_o);
    end
  endtask

  task automatic test_check();
    out_ready_i = 1'b1;
    drive(4'b0011, 4'b0011, 0, 8'h5A);
    tick();
    idle();
    #1;
    n_checks++;
    if (err_o !== ERR_EXP) begin
      n_fail++;
      $display("FAIL check_multi_hot: err=%b, required %b", err_o, ERR_EXP);
    end
    tick();
    tick();
    n_checks++;
    if (err_o !== ERR_EXP) begin
      n_fail++;
      $display("FAIL check_sticky: err=%b, required %b", err_o, ERR_EXP);
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL check_reset: err=%b, required 0", err_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_gnt_no_valid();
    out_ready_i = 1'b0;
    req_valid_i = 4'b0000;
    gnt_i       = 4'b0001;
    req_data_i  = 32'h0000_00EE;
    tick();
    idle();
    #1;
    n_checks++;
    if (out_valid_o !== 1'b0 || err_o !== ERR_EXP) begin
      n_fail++;
      $display("FAIL gnt_no_valid: valid=%b err=%b, required 0 %b", out_valid_o, err_o, ERR_EXP);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_streaming();
    test_push_pop_cnt1();
    test_reset_mid();
    test_check();
    test_gnt_no_valid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
